// File: rtl/nios_link_pkg.sv
// rtl/nios_link_pkg.sv - shared widths and word type for the NIOS receive PIO link
package nios_link_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_OFS_W  = 7;
    localparam int DEF_DEPTH  = 1 << DEF_OFS_W;

    typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/nios_recv_buffer_if.sv
// rtl/nios_recv_buffer_if.sv - ReCOP datacall stream and NIOS recv PIO signals
interface nios_recv_buffer_if #(
    parameter int DATA_W = nios_link_pkg::DEF_DATA_W,
    parameter int OFS_W  = nios_link_pkg::DEF_OFS_W
);

    logic              pkt_valid;
    logic [DATA_W-1:0] pkt_data;
    logic              pkt_ready;
    logic [OFS_W:0]    recv_addr;
    logic [DATA_W-1:0] recv_data;
    logic              pk_input;

    // master: ReCOP producer plus NIOS reader; slave: the buffer itself
    modport master (
        output pkt_valid,
        output pkt_data,
        output recv_addr,
        input  pkt_ready,
        input  recv_data,
        input  pk_input
    );

    modport slave (
        input  pkt_valid,
        input  pkt_data,
        input  recv_addr,
        output pkt_ready,
        output recv_data,
        output pk_input
    );

endinterface

// File: rtl/nios_recv_buffer_dpram.sv
// rtl/nios_recv_buffer_dpram.sv - simple dual-port RAM with registered read, M10K-inferable
module recv_dpram
    import nios_link_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_OFS_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    // no reset and read-old-data on collision so the block maps onto a RAM primitive
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/nios_recv_buffer.sv
// rtl/nios_recv_buffer.sv - circular receive buffer between ReCOP datacalls and the NIOS recv PIOs
module nios_recv_buffer
    import nios_link_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OFS_W  = DEF_OFS_W
) (
    input  logic           clk,
    input  logic           reset,
    nios_recv_buffer_if.slave link,
    output logic [OFS_W:0] count,
    output logic           overflow
);

    localparam logic [OFS_W:0]   CNT_FULL = {1'b1, {OFS_W{1'b0}}};
    localparam logic [OFS_W:0]   CNT_ONE  = {{OFS_W{1'b0}}, 1'b1};
    localparam logic [OFS_W-1:0] PTR_ONE  = {{(OFS_W-1){1'b0}}, 1'b1};

    logic [OFS_W-1:0]  wr_ptr;
    logic [OFS_W-1:0]  rd_ptr;
    logic [OFS_W-1:0]  rd_ptr_nxt;
    logic [OFS_W-1:0]  offset;
    logic [OFS_W-1:0]  rd_idx;
    logic [OFS_W:0]    count_nxt;
    logic              ack_bit;
    logic              ack_q;
    logic              wr_en;
    logic              pop;
    logic              in_range;
    logic              rd_valid_q;
    logic [DATA_W-1:0] ram_q;

    assign link.pkt_ready = (count != CNT_FULL);

    // Pointer/count update; the read index is taken from post-update state so a pop
    // is reflected in recv_data on the very next cycle.
    always_comb begin
        ack_bit    = link.recv_addr[OFS_W];
        offset     = link.recv_addr[OFS_W-1:0];
        wr_en      = link.pkt_valid && link.pkt_ready;
        pop        = (ack_bit ^ ack_q) && (count != '0);
        count_nxt  = count;
        rd_ptr_nxt = rd_ptr;
        if (wr_en && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (!wr_en && pop) begin
            count_nxt = count - CNT_ONE;
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + PTR_ONE;
        end
        rd_idx   = rd_ptr_nxt + offset;
        in_range = ({1'b0, offset} < count_nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            ack_q         <= 1'b0;
            overflow      <= 1'b0;
            rd_valid_q    <= 1'b0;
            link.pk_input <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (link.pkt_valid && !link.pkt_ready) begin
                overflow <= 1'b1;
            end
            rd_ptr        <= rd_ptr_nxt;
            count         <= count_nxt;
            ack_q         <= ack_bit;
            rd_valid_q    <= in_range;
            link.pk_input <= (count_nxt != '0);
        end
    end

    recv_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (OFS_W)
    ) u_dpram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (link.pkt_data),
        .rd_addr (rd_idx),
        .rd_data (ram_q)
    );

    // out-of-range offsets read as zero; the flag also forces zero straight out of reset
    assign link.recv_data = rd_valid_q ? ram_q : '0;

endmodule

// File: tb/tb_nios_recv_buffer.sv
// tb/tb_nios_recv_buffer.sv - randomized self-checking bench for nios_recv_buffer
module tb_nios_recv_buffer;
    import nios_link_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] count;
    logic       overflow;

    nios_recv_buffer_if #(.DATA_W(32), .OFS_W(7)) bus ();

    nios_recv_buffer #(.DATA_W(32), .OFS_W(7)) dut (
        .clk      (clk),
        .reset    (reset),
        .link     (bus),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    word_t q[$];
    bit    m_ovf;
    bit    ack_lvl;
    word_t exp_data;
    bit    exp_chk;

    // One cycle of stimulus from a negedge to the next; the model is a plain FIFO queue.
    task automatic drive(input bit v, input word_t d, input bit tog, input int ofs);
        bit wr;
        bus.pkt_valid = v;
        bus.pkt_data  = d;
        if (tog) ack_lvl = ~ack_lvl;
        bus.recv_addr = {ack_lvl, 7'(ofs)};
        wr = v && (q.size() < 128);
        if (v && !wr) m_ovf = 1'b1;
        if (tog && q.size() != 0) void'(q.pop_front());
        if (wr) q.push_back(d);
        exp_chk  = 1'b1;
        exp_data = '0;
        if (ofs < q.size()) begin
            if (wr && ofs == q.size() - 1) exp_chk = 1'b0;
            else exp_data = q[ofs];
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.pkt_data  = '0;
        bus.recv_addr = '0;
        ack_lvl = 1'b0;
        m_ovf = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (bus.pk_input !== 1'b0) begin errors++; $display("FAIL reset_pk_input: got %b expected 0", bus.pk_input); end
        checks++; if (bus.recv_data !== 32'h0) begin errors++; $display("FAIL reset_recv_data: got %h expected 0", bus.recv_data); end
        checks++; if (bus.pkt_ready !== 1'b1) begin errors++; $display("FAIL reset_pkt_ready: got %b expected 1", bus.pkt_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        reset = 1'b0;
        drive(0, '0, 0, 5);
        checks++; if (bus.recv_data !== 32'h0) begin errors++; $display("FAIL idle_ofs5: got %h expected 0", bus.recv_data); end
    endtask

    task automatic test_write3();
        word_t tbl [4];
        tbl = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'h0};
        for (int i = 0; i < 3; i++) drive(1, tbl[i], 0, 0);
        checks++; if (count !== 8'd3) begin errors++; $display("FAIL write3_count: got %0d expected 3", count); end
        checks++; if (bus.pk_input !== 1'b1) begin errors++; $display("FAIL write3_pk_input: got %b expected 1", bus.pk_input); end
        for (int o = 0; o < 4; o++) begin
            drive(0, '0, 0, o);
            checks++;
            if (bus.recv_data !== tbl[o]) begin errors++; $display("FAIL write3_ofs%0d: got %h expected %h", o, bus.recv_data, tbl[o]); end
        end
    endtask

    task automatic test_pop();
        drive(0, '0, 1, 0);
        checks++; if (count !== 8'd2) begin errors++; $display("FAIL pop_count: got %0d expected 2", count); end
        checks++; if (bus.recv_data !== 32'hA0000002) begin errors++; $display("FAIL pop_head: got %h expected a0000002", bus.recv_data); end
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);
        checks++; if (bus.pk_input !== 1'b0) begin errors++; $display("FAIL pop_empty_pk: got %b expected 0", bus.pk_input); end
        drive(0, '0, 1, 0);
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL pop_on_empty: got %0d expected 0", count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 128; i++) drive(1, 32'hB0000000 + 32'(i), 0, 0);
        checks++; if (bus.pkt_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b expected 0", bus.pkt_ready); end
        drive(1, 32'hDEADBEEF, 0, 127);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b expected 1", overflow); end
        checks++; if (count !== 8'd128) begin errors++; $display("FAIL fill_count: got %0d expected 128", count); end
        checks++; if (bus.recv_data !== 32'hB000007F) begin errors++; $display("FAIL fill_ofs127: got %h expected b000007f", bus.recv_data); end
        for (int i = 1; i <= 128; i++) begin
            drive(0, '0, 1, 0);
            checks++;
            if (bus.recv_data !== exp_data) begin errors++; $display("FAIL drain_%0d: got %h expected %h", i, bus.recv_data, exp_data); end
        end
        checks++; if (count !== 8'd0 || bus.pk_input !== 1'b0) begin errors++; $display("FAIL drain_empty: got count %0d pk %b expected 0 0", count, bus.pk_input); end
        for (int i = 0; i < 4; i++) drive(1, 32'hC0000000 + 32'(i), 0, 0);
        for (int o = 0; o < 4; o++) begin
            drive(0, '0, 0, o);
            checks++;
            if (bus.recv_data !== 32'hC0000000 + 32'(o)) begin errors++; $display("FAIL refill_ofs%0d: got %h expected %h", o, bus.recv_data, 32'hC0000000 + 32'(o)); end
        end
    endtask

    task automatic test_same_cycle();
        while (q.size() > 1) drive(0, '0, 1, 0);
        drive(1, 32'hD0000001, 1, 0);
        checks++; if (count !== 8'd1) begin errors++; $display("FAIL same_cycle_count: got %0d expected 1", count); end
        drive(0, '0, 0, 0);
        checks++; if (bus.recv_data !== 32'hD0000001) begin errors++; $display("FAIL same_cycle_head: got %h expected d0000001", bus.recv_data); end
    endtask

    task automatic test_reset_mid();
        while (q.size() < 50) drive(1, $urandom, 0, 0);
        checks++; if (count !== 8'd50) begin errors++; $display("FAIL mid_fill_count: got %0d expected 50", count); end
        bus.recv_addr = {ack_lvl, 7'd2};
        #2 reset = 1'b1;
        #1;
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL mid_reset_count: got %0d expected 0", count); end
        checks++; if (bus.pk_input !== 1'b0 || bus.pkt_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_flags: got pk %b ready %b expected 0 1", bus.pk_input, bus.pkt_ready); end
        checks++; if (bus.recv_data !== 32'h0) begin errors++; $display("FAIL mid_reset_data: got %h expected 0", bus.recv_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_overflow: got %b expected 0", overflow); end
        ack_lvl = 1'b0;
        bus.recv_addr = '0;
        bus.pkt_valid = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        drive(1, 32'hE0000000, 0, 0);
        drive(0, '0, 0, 0);
        checks++; if (bus.recv_data !== 32'hE0000000) begin errors++; $display("FAIL post_reset_ofs0: got %h expected e0000000", bus.recv_data); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            bit v, tog;
            int ofs;
            v   = (n < 700) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            tog = (n < 700) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            if (q.size() != 0 && $urandom_range(0, 3) != 0) ofs = $urandom_range(0, q.size() - 1);
            else ofs = $urandom_range(0, 127);
            drive(v, $urandom, tog, ofs);
            checks++;
            if (count !== 8'(q.size()) || bus.pk_input !== (q.size() != 0) || bus.pkt_ready !== (q.size() != 128) || overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_state_%0d: got cnt %0d pk %b rdy %b ovf %b expected %0d %b %b %b", n, count, bus.pk_input, bus.pkt_ready, overflow, q.size(), q.size() != 0, q.size() != 128, m_ovf);
            end
            if (exp_chk) begin
                checks++;
                if (bus.recv_data !== exp_data) begin errors++; $display("FAIL rand_data_%0d: ofs %0d got %h expected %h", n, ofs, bus.recv_data, exp_data); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write3();
        test_pop();
        test_fill();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
